// File: rtl/image_mem_reader_if.sv
// Row stream from the image memory reader to its consumer.
// Valid/ready handshake; a beat moves when both are high.
interface image_mem_reader_if #(
  parameter int DATA_W = 1024
) ();
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/image_mem_reader.sv
// Ping-pong image memory reader: streams filled blocks in turn
// through a 2-entry FIFO and hands each block back when drained.
module image_mem_reader #(
  parameter int IMAGE_MEM_DEPTH_BITS = 13,
  parameter int DATA_W = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fill_done,
  input  logic                            fill_block,
  input  logic [IMAGE_MEM_DEPTH_BITS:0]   fill_count,
  output logic [IMAGE_MEM_DEPTH_BITS-1:0] read_address,
  output logic                            select_block_rd,
  input  logic [DATA_W-1:0]               mem_data,
  image_mem_reader_if.master              stream,
  output logic [1:0]                      block_full,
  output logic                            free_pulse,
  output logic                            free_block,
  output logic                            err_overflow
);

  localparam int AW = IMAGE_MEM_DEPTH_BITS;
  localparam logic [AW:0] MAX_ROWS = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_ROW = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t            state;
  logic              rd_sel;
  logic [AW:0]       remaining;
  logic [AW:0]       count [2];

  logic              pend;
  logic              pend_last;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;

  logic              pop;
  logic              issue;
  logic              fill_range;
  logic              fill_ok;
  logic              fill_err;
  logic              drained;
  logic [2:0]        used;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;

  assign select_block_rd  = rd_sel;
  assign stream.out_valid = (occ != 2'd0);
  assign stream.out_data  = fifo_data[rd_ptr];
  assign stream.out_last  = fifo_last[rd_ptr];
  assign pop = stream.out_valid & stream.out_ready;

  // Issue credit counts a slot freed by this cycle's pop,
  // which keeps one row per cycle with a 2-deep FIFO.
  always_comb begin
    used = {1'b0, occ} + {2'b00, pend};
    issue = (state == READ) && (used < (3'd2 + {2'b00, pop}));
    fill_range = (fill_count != '0) && (fill_count <= MAX_ROWS);
    fill_ok = fill_done && !block_full[fill_block] && fill_range;
    fill_err = fill_done && !fill_ok;
    drained = (state == DRAIN) && pop && stream.out_last;
    full_set = '0;
    full_clr = '0;
    if (fill_ok) full_set[fill_block] = 1'b1;
    if (drained) full_clr[rd_sel] = 1'b1;
  end

  // Block ownership, fill bookkeeping and the read sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_sel       <= 1'b0;
      remaining    <= '0;
      read_address <= '0;
      count[0]     <= '0;
      count[1]     <= '0;
      block_full   <= '0;
      free_pulse   <= 1'b0;
      free_block   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      free_pulse <= 1'b0;
      block_full <= (block_full & ~full_clr) | full_set;
      if (fill_err) err_overflow <= 1'b1;
      if (fill_ok) count[fill_block] <= fill_count;
      unique case (state)
        IDLE: begin
          if (block_full[rd_sel]) begin
            remaining    <= count[rd_sel];
            read_address <= '0;
            state        <= READ;
          end
        end
        READ: begin
          if (issue) begin
            read_address <= read_address + AW'(1);
            remaining    <= remaining - ONE_ROW;
            if (remaining == ONE_ROW) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            free_pulse <= 1'b1;
            free_block <= rd_sel;
            rd_sel     <= ~rd_sel;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture returning rows into the output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend         <= 1'b0;
      pend_last    <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue && (remaining == ONE_ROW);
      if (pend) begin
        fifo_data[wr_ptr] <= mem_data;
        fifo_last[wr_ptr] <= pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, pend} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_image_mem_reader.sv
// Self-checking bench for image_mem_reader: directed scenarios
// followed by random fills/backpressure against a block-level model.
module tb_image_mem_reader;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int ROWS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fill_done = 1'b0;
  logic          fill_block = 1'b0;
  logic [AW:0]   fill_count = '0;
  logic [AW-1:0] read_address;
  logic          select_block_rd;
  logic [DW-1:0] mem_data = '0;
  logic [1:0]    block_full;
  logic          free_pulse;
  logic          free_block;
  logic          err_overflow;

  image_mem_reader_if #(.DATA_W(DW)) bus ();

  image_mem_reader #(
    .IMAGE_MEM_DEPTH_BITS(AW),
    .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fill_done(fill_done),
    .fill_block(fill_block),
    .fill_count(fill_count),
    .read_address(read_address),
    .select_block_rd(select_block_rd),
    .mem_data(mem_data),
    .stream(bus.master),
    .block_full(block_full),
    .free_pulse(free_pulse),
    .free_block(free_block),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Two synchronous-read image blocks behind the block mux.
  logic [DW-1:0] mem [2][ROWS];
  always @(posedge clk) mem_data <= mem[select_block_rd][read_address];

  int errors = 0;
  int checks = 0;

  logic [1:0]    full_m;
  int            cnt_m [2];
  logic [DW-1:0] snap [2][ROWS];
  bit            sel_m;
  int            row_m;
  bit            fp_m;
  bit            fb_m;
  bit            err_m;
  int            beats;
  bit            p_valid;
  bit            p_ready;
  logic [DW-1:0] p_data;
  logic [AW-1:0] s_addr;
  bit            s_valid;
  bit            s_last;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    full_m = '0;
    sel_m = 1'b0;
    row_m = 0;
    fp_m = 1'b0;
    fb_m = 1'b0;
    err_m = 1'b0;
    p_valid = 1'b0;
    p_ready = 1'b0;
  endtask

  task automatic load(input bit b, input int n);
    for (int i = 0; i < n; i++) mem[b][i] = {$urandom, $urandom};
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic tick(input bit fd, input bit fb, input int fc,
                      input bit rdy);
    bit last_b;
    bit acc;
    @(negedge clk);
    fill_done = fd;
    fill_block = fb;
    fill_count = fc[AW:0];
    bus.out_ready = rdy;
    chk("block_full", block_full, full_m);
    chk("err_overflow", err_overflow, err_m);
    chk("select_block_rd", select_block_rd, sel_m);
    chk("free_pulse", free_pulse, fp_m);
    if (fp_m) chk("free_block", free_block, fb_m);
    if (p_valid && !p_ready) begin
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_data", bus.out_data, p_data);
    end
    last_b = 1'b0;
    if (bus.out_valid && rdy) begin
      chk("beat_owner", full_m[sel_m], 1'b1);
      if (full_m[sel_m] && row_m < ROWS) begin
        chk("row_data", bus.out_data, snap[sel_m][row_m]);
        chk("row_last", bus.out_last, row_m == cnt_m[sel_m] - 1);
        last_b = (row_m == cnt_m[sel_m] - 1);
        row_m++;
      end
      beats++;
    end
    acc = fd && !full_m[fb] && fc >= 1 && fc <= ROWS;
    if (fd && !acc) err_m = 1'b1;
    fp_m = 1'b0;
    if (last_b) begin
      full_m[sel_m] = 1'b0;
      fp_m = 1'b1;
      fb_m = sel_m;
      sel_m = ~sel_m;
      row_m = 0;
    end
    if (acc) begin
      full_m[fb] = 1'b1;
      cnt_m[fb] = fc;
      for (int i = 0; i < fc; i++) snap[fb][i] = mem[fb][i];
    end
    p_valid = bus.out_valid;
    p_ready = rdy;
    p_data = bus.out_data;
    s_addr = read_address;
    s_valid = bus.out_valid;
    s_last = bus.out_last;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, read_address, 0);
    chk({tag, "_sel"}, select_block_rd, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_full"}, block_full, 0);
    chk({tag, "_fpulse"}, free_pulse, 0);
    chk({tag, "_fblock"}, free_block, 0);
    chk({tag, "_err"}, err_overflow, 0);
  endtask

  initial begin
    bit ev [10];
    logic [AW-1:0] ea [10];
    int b0;
    bit seen;
    bit b;
    int n;
    int k;

    bus.out_ready = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      mem[0][i] = '0;
      mem[1][i] = '0;
    end
    model_reset();
    beats = 0;

    // Reset state.
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Block 0, four rows, free-running consumer: timing profile.
    load(0, 4);
    tick(1, 0, 4, 1);
    ev[0] = s_valid;
    ea[0] = s_addr;
    for (int i = 1; i < 10; i++) begin
      tick(0, 0, 0, 1);
      ev[i] = s_valid;
      ea[i] = s_addr;
    end
    for (int i = 0; i < 10; i++)
      chk($sformatf("lat_valid_%0d", i), ev[i], (i >= 4 && i <= 7));
    for (int i = 2; i < 6; i++)
      chk($sformatf("issue_addr_%0d", i), ea[i], i - 2);

    // Block 1, four rows, consumer stalls in a 1,0,0 pattern.
    b0 = beats;
    load(1, 4);
    tick(1, 1, 4, 1);
    for (int i = 1; i < 20; i++) tick(0, 0, 0, (i % 3) == 0);
    chk("stall_rows", beats - b0, 4);

    // Zero-length fill is rejected.
    tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("zero_cnt_full", block_full, 0);

    // Reset while the reader holds a drained-but-unconsumed block.
    load(0, 2);
    tick(1, 0, 2, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    chk("pre_reset_valid", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst_n = 1'b1;
    b0 = beats;
    load(0, 3);
    tick(1, 0, 3, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("post_rst_addr0", s_addr, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1);
    chk("post_rst_rows", beats - b0, 3);

    // Oversized fill is rejected.
    tick(1, 1, ROWS + 1, 1);
    tick(0, 0, 0, 1);
    chk("big_cnt_err", err_overflow, 1'b1);

    // Full-depth block: address wraps to zero after the last row.
    load(1, ROWS);
    tick(1, 1, ROWS, 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(0, 0, 0, 1);
      if (s_valid && s_last) begin
        seen = 1'b1;
        chk("wrap_addr", s_addr, 0);
      end
    end
    chk("wrap_seen", seen, 1'b1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);

    // Second block filled while the first is being read.
    b0 = beats;
    load(0, 3);
    tick(1, 0, 3, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    load(1, 2);
    tick(1, 1, 2, 1);
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 1);
    chk("pair_rows", beats - b0, 5);

    // Double fill of the same block: second is an overflow.
    b0 = beats;
    load(0, 3);
    tick(1, 0, 3, 1);
    tick(1, 0, 5, 1);
    for (int i = 0; i < 15; i++) tick(0, 0, 0, 1);
    chk("dbl_rows", beats - b0, 3);
    chk("dbl_err", err_overflow, 1'b1);

    // Random fills and backpressure.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, 1);
        k = $urandom_range(0, 7);
        n = (k == 0) ? 0 : (k == 1) ? ROWS + 1 : $urandom_range(1, ROWS);
        if (!full_m[b] && n >= 1 && n <= ROWS) load(b, n);
        tick(1, b, n, $urandom_range(0, 3) != 0);
      end else begin
        tick(0, 0, 0, $urandom_range(0, 3) != 0);
      end
    end

    // Drain whatever is left.
    for (int i = 0; i < 300 && !(full_m == 2'b00 && !s_valid); i++)
      tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("drain_idle", full_m, 0);
    chk("drain_full", block_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
